rsub_divider: RTL
=================

# rsub_divider

Unsigned integer divider by repeated subtraction: the inverse companion to the team's repeated-addition multiplier, built in the same datapath-plus-controller style. The dividend and divisor arrive on one shared input bus in consecutive cycles. The block subtracts the divisor from a running remainder once per clock, incrementing the quotient each time, until the remainder is less than the divisor. It then presents quotient, remainder and a divide-by-zero flag with a sticky `done`.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width in bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `data_in`  in  WIDTH  shared operand bus: dividend on the `start` cycle, divisor on the following cycle.
- `busy`  out  1  high in LOAD_D and CALC.
- `done`  out  1  high in DONE; held until the next accepted `start` or reset.
- `div_by_zero`  out  1  high in DONE when the captured divisor was 0.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.

## Operation
- States: IDLE, LOAD_D, CALC, DONE. Encoding is free. Unused encodings return to IDLE.
- Internal registers:
  - R: remainder, which drives `remainder`.
  - Q: quotient, which drives `quotient`.
  - D: divisor.
  - div_by_zero flag.
- IDLE or DONE with `start`=1, rising edge:
  - R <= `data_in`, Q <= 0, flag <= 0.
  - State <= LOAD_D.
  - `done` drops after this edge.
- IDLE or DONE with `start`=0: hold all registers.
- LOAD_D, rising edge:
  - D <= `data_in`.
  - If `data_in`==0: flag <= 1 and state <= DONE. Q stays 0 and R stays equal to the dividend.
  - Otherwise: state <= CALC.
- CALC, rising edge:
  - If R >= D: R <= R - D, Q <= Q + 1, stay in CALC.
  - Otherwise: state <= DONE.
- Arithmetic:
  - Unsigned WIDTH-bit values throughout.
  - The R >= D comparison is unsigned, and the subtraction never underflows.
  - Q cannot overflow because D >= 1.
- `start` in LOAD_D or CALC is ignored and has no effect on the current operation.
- `data_in` is don't-care outside the `start` cycle and the LOAD_D cycle.

## Timing
- Reset, while `rst_n`=0, independent of `clk`:
  - State = IDLE.
  - R, Q, D = 0.
  - `busy`, `done`, `div_by_zero` = 0.
  - `quotient` = `remainder` = 0.
- Reset applied mid-operation aborts the operation immediately. No `done` is produced for the aborted operation.
- Let edge k accept `start` and q be the true quotient. Then:
  - `busy` is high from after edge k until edge k+q+2.
  - `done` rises after edge k+q+2.
  - Total latency is q+2 cycles from acceptance.
- Divisor 0: `done` and `div_by_zero` rise after edge k+1.
- Outputs are registered only, with no combinational path from inputs to outputs.
- `quotient` and `remainder` are final and stable throughout DONE.
- During CALC, `quotient` and `remainder` show intermediate values and are not valid.
- Back-to-back operation: `start` is accepted on the first DONE cycle. The minimum gap between `done` and the next accepted `start` is therefore 0 cycles.

## Test plan
- Dividend 100 at edge k, divisor 7 at edge k+1 -> `done` after edge k+16, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Dividend 5, divisor 9 -> `done` after edge k+2, `quotient`=0, `remainder`=5. Dividend 0, divisor 3 -> `quotient`=0, `remainder`=0, `done` after edge k+2.
- Dividend 1234, divisor 0 -> `done` and `div_by_zero` high after edge k+1, `quotient`=0, `remainder`=1234.
- Dividend 65535, divisor 1 -> `quotient`=65535, `remainder`=0, `done` after edge k+65537. Dividend 65535, divisor 65535 -> `quotient`=1, `remainder`=0.
- 50/6 in progress, `start`=1 with `data_in`=9 pulsed during CALC -> ignored, final `quotient`=8, `remainder`=2. A new `start` on the first DONE cycle then runs 9/4 -> `quotient`=2, `remainder`=1.
- `rst_n` driven low mid-CALC of 1000/3, between clock edges -> all outputs 0 immediately, state IDLE. After release, 20/5 gives `quotient`=4, `remainder`=0.

Source files
------------

// File: rtl/rsub_divider.sv
`default_nettype none
// ============================================================================
// Module      : rsub_divider
// Description : Unsigned integer divider by repeated subtraction. The
//               dividend arrives on data_in in the start cycle and the divisor
//               on the following cycle. One subtraction is performed per
//               clock until the remainder drops below the divisor.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               start        - request, honoured only in IDLE or DONE
//               data_in      - dividend (start cycle), divisor (next cycle)
//               busy         - high while loading the divisor or subtracting
//               done         - high in DONE, held until next accepted start
//               div_by_zero  - high in DONE when the divisor was 0
//               quotient     - registered quotient
//               remainder    - registered remainder
// Revision    : 1.0 - initial release
// ============================================================================
module rsub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_D = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_dbz;
    logic             w_accept;
    logic             w_ge;

    // start is only honoured when no operation is in flight
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_ge     = (r_rem >= r_div);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD_D;
            end
            S_LOAD_D: begin
                w_next = (data_in == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (!w_ge) w_next = S_DONE;
            end
            S_DONE: begin
                if (w_accept) w_next = S_LOAD_D;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_dbz <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem <= data_in;
                r_quo <= '0;
                r_dbz <= 1'b0;
            end else if (r_state == S_LOAD_D) begin
                r_div <= data_in;
                if (data_in == '0) r_dbz <= 1'b1;
            end else if ((r_state == S_CALC) && w_ge) begin
                // w_ge guarantees no underflow; divisor >= 1 bounds the count
                r_rem <= r_rem - r_div;
                r_quo <= r_quo + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Outputs are decoded only from registers
    assign busy        = (r_state == S_LOAD_D) || (r_state == S_CALC);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;
    assign quotient    = r_quo;
    assign remainder   = r_rem;

endmodule
`default_nettype wire
